mac_bank_reader: RTL

Read-side controller for the MAC unit's latch-based coefficient/result bank, the counterpart to the bank's write path. It accepts a burst read request (start address, length), sequences single-word reads into the bank with a fixed read latency, and returns each word over a valid/ready response channel with a last-word flag. It sits between the bank's read port and the MAC datapath or host readout logic.

---
 rtl/mac_bank_reader.sv | 125 ++++++++++++
 1 files changed

// File: rtl/mac_bank_reader.sv
`default_nettype none
// ============================================================================
// Module      : mac_bank_reader
// Description : Read-side burst controller for the MAC coefficient/result
//               bank. Accepts a burst request (start address, length-1),
//               issues one bank read per word, waits a fixed read latency,
//               and returns each word on a valid/ready channel with a
//               last-word flag.
// Ports       : clk, rst_n            - clock, async active-low reset
//               req_valid/req_ready   - burst request handshake
//               req_addr, req_len     - first address, burst length minus one
//               mem_en, mem_addr      - bank read strobe and address
//               mem_rdata             - bank read data (RD_LAT after mem_en)
//               rsp_valid/rsp_ready   - response handshake
//               rsp_data, rsp_last    - response word, final-word flag
//               busy                  - burst in progress
// Revision    : 1.0 - initial release
// ============================================================================
module mac_bank_reader #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [ADDR_W-1:0] req_len,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_last,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [1:0] C_LAT_INIT = 2'(RD_LAT);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [ADDR_W-1:0] rem_q,   rem_d;
    logic [1:0]        lat_q,   lat_d;
    logic [DATA_W-1:0] data_q,  data_d;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        lat_d   = lat_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    rem_d   = req_len;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                lat_d   = C_LAT_INIT;
                state_d = WAIT;
            end
            WAIT: begin
                // Counter value 1 marks the cycle ISSUE+RD_LAT, when the
                // bank data is valid on mem_rdata.
                if (lat_q == 2'd1) begin
                    data_d  = mem_rdata;
                    state_d = RESP;
                end
                lat_d = lat_q - 2'd1;
            end
            RESP: begin
                if (rsp_ready) begin
                    if (rem_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        rem_d   = rem_q - 1'b1;
                        // Natural wrap of the ADDR_W-bit register.
                        addr_d  = addr_q + 1'b1;
                        state_d = ISSUE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            lat_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            lat_q   <= lat_d;
            data_q  <= data_d;
        end
    end

    // Outputs decode registered state only; nothing combinational from
    // req_valid or rsp_ready reaches an output.
    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign mem_en    = (state_q == ISSUE);
    assign mem_addr  = (state_q == ISSUE) ? addr_q : '0;
    assign rsp_valid = (state_q == RESP);
    assign rsp_last  = (state_q == RESP) && (rem_q == '0);
    assign rsp_data  = data_q;

endmodule
`default_nettype wire
